uart_top_rx: RTL
================

UART_TOP_RX -- requirements
Module: uart_top_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter CHAR_COUNT, default 32, hex characters per 128-bit block.
REQ-004 Parameter TIMEOUT_CHARS, default 20, idle character-times allowed inside a partial frame.
REQ-005 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-006 i_reset_n  input  1  reset, synchronous, active-low.
REQ-007 i_uart_rxd  input  1  physical RX pin, asynchronous, idle high.
REQ-008 o_data  output  128  assembled block; first received character occupies bits [127:124].
REQ-009 o_data_valid  output  1  one-cycle pulse when o_data holds a new complete block.
REQ-010 o_error  output  1  one-cycle pulse when a partial frame is discarded.
REQ-011 o_busy  output  1  high while a partial frame (1..CHAR_COUNT-1 characters) is held.

Function
REQ-012 i_uart_rxd SHALL pass a 2-flop synchronizer before any use.
REQ-013 Bit timing SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), 8N1, LSB first.
REQ-014 Start detect: falling edge; re-sample at CLKS_PER_BIT/2; if high, treat as glitch and return to idle without a byte.
REQ-015 Data bits sampled at bit centres; stop bit sampled at its centre; stop=0 is a framing error.
REQ-016 Byte strobe (one cycle) SHALL issue at the stop-bit centre, carrying byte and framing-error flag.
REQ-017 Hex decode: '0'-'9' -> 0-9, 'A'-'F' and 'a'-'f' -> 10-15.
REQ-018 Bytes 0x0A, 0x0D, 0x20 SHALL be ignored: no count change, no error, timeout not restarted.
REQ-019 Valid hex byte: shift register shifts left 4, nibble enters [3:0], char counter +1.
REQ-020 Any other byte, or a framing error, SHALL clear shift register and counter and pulse o_error, whether or not a frame was in progress.
REQ-021 Assembler states: S_IDLE (counter 0), S_COLLECT (counter 1..CHAR_COUNT-1), S_DONE (one cycle).
REQ-022 The CHAR_COUNT-th valid hex byte SHALL cause a transition to S_DONE; on that edge, o_data <= completed shift value and counter <= 0.
REQ-023 o_data_valid SHALL be high exactly during the S_DONE cycle, one cycle after the final strobe; S_DONE -> S_IDLE unconditionally.
REQ-024 A byte strobe arriving in S_DONE SHALL be processed as in S_IDLE.
REQ-025 o_data SHALL hold its value until the next completed block; errors never alter it.
REQ-026 In S_COLLECT, no valid hex byte for TIMEOUT_CHARS*10*CLKS_PER_BIT cycles SHALL discard the frame, pulse o_error, and return to S_IDLE.
REQ-027 o_busy = (state == S_COLLECT).
REQ-028 Counter width SHALL be $clog2(CHAR_COUNT)+1 to avoid wrap at the final increment.

Reset
REQ-029 While i_reset_n=0 at a clock edge: o_data=0, o_data_valid=0, o_error=0, o_busy=0, state S_IDLE, counter 0, receiver idle, synchronizer flops set to 1.
REQ-030 Reset mid-byte or mid-frame SHALL abandon the byte/frame with no o_error or o_data_valid pulse.

Structure
REQ-031 Shared package uart_pkg SHALL hold CLK_FREQ, BAUD_RATE, CHAR_COUNT defaults, ASCII constants ('0','A','a',CR,LF,SP), and state encodings; uart_top_tx imports the same constants.
REQ-032 Sub-module uart_rx SHALL contain the synchronizer, bit timing, and byte strobe; uart_top_rx contains hex decode, assembler FSM, and timeout.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit)
REQ-033 Send "00112233445566778899AABBCCDDEEFF" -> single o_data_valid pulse, o_data=128'h00112233445566778899AABBCCDDEEFF, o_error never high.
REQ-034 Send 32 lowercase chars "deadbeef" x4, with CR LF after char 16 -> o_data=128'hDEADBEEF DEADBEEF DEADBEEF DEADBEEF, one valid pulse.
REQ-035 Send 10 hex chars, then 'G', then 32x'1' -> one o_error pulse at 'G', then o_data=128'h1111...1111 (32 ones), o_busy low after 'G'.
REQ-036 Send 5 chars, one byte with stop bit 0, then 32x'F' -> o_error pulse, then o_data=all ones; 3-cycle low glitch on idle line -> no strobe.
REQ-037 Send 4 chars, idle 20*100+1 cycles -> o_error pulse, o_busy low; previous o_data unchanged.
REQ-038 Assert i_reset_n=0 for 1 cycle after char 20 -> all outputs 0; next full 32-char frame assembles correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults, ASCII constants and state encodings
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD_RATE = 9600;
    localparam int DEF_CHAR_COUNT = 32;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } asm_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with input synchronizer and one-cycle byte strobe
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic       strobe,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync_a;
    logic            sync_b;
    logic            rxd_prev;
    rx_state_t       state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_a   <= 1'b1;
            sync_b   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync_a   <= rxd;
            sync_b   <= sync_a;
            rxd_prev <= sync_b;
        end
    end

    // Bit-timing FSM: half-bit start check, centre-sampled data and stop bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= RX_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
            strobe    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            strobe <= 1'b0;
            case (state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rxd_prev && !sync_b) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= sync_b ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        rx_byte <= {sync_b, rx_byte[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        strobe    <= 1'b1;
                        frame_err <= ~sync_b;
                        state     <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_top_rx.sv
// rtl/uart_top_rx.sv - hex-character UART receiver assembling 128-bit blocks
module uart_top_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = DEF_CLK_FREQ,
    parameter int BAUD_RATE     = DEF_BAUD_RATE,
    parameter int CHAR_COUNT    = DEF_CHAR_COUNT,
    parameter int TIMEOUT_CHARS = 20
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_uart_rxd,
    output logic [4*CHAR_COUNT-1:0] o_data,
    output logic                    o_data_valid,
    output logic                    o_error,
    output logic                    o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int TMO_CYCLES   = TIMEOUT_CHARS * 10 * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CHAR_COUNT) + 1;
    localparam int TMO_W        = $clog2(TMO_CYCLES + 1);
    localparam int DW           = 4 * CHAR_COUNT;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAR_COUNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic             strobe;
    logic [7:0]       rx_byte;
    logic             frame_err;
    logic             is_hex;
    logic             is_ws;
    logic [3:0]       nibble;
    asm_state_t       state;
    logic [DW-1:0]    shift;
    logic [CNT_W-1:0] char_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .rxd      (i_uart_rxd),
        .strobe   (strobe),
        .rx_byte  (rx_byte),
        .frame_err(frame_err)
    );

    // ASCII hex decode; whitespace is recognised separately so it can be skipped.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        is_ws  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF) || (rx_byte == ASCII_SP);
        if (rx_byte >= ASCII_0 && rx_byte <= ASCII_0 + 8'd9) begin
            is_hex = 1'b1;
            nibble = 4'(rx_byte - ASCII_0);
        end else if (rx_byte >= ASCII_UA && rx_byte <= ASCII_UA + 8'd5) begin
            is_hex = 1'b1;
            nibble = 4'(rx_byte - ASCII_UA + 8'd10);
        end else if (rx_byte >= ASCII_LA && rx_byte <= ASCII_LA + 8'd5) begin
            is_hex = 1'b1;
            nibble = 4'(rx_byte - ASCII_LA + 8'd10);
        end
    end

    // Block assembler: collects hex nibbles, publishes full blocks, discards on bad input or timeout.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            shift        <= '0;
            char_cnt     <= '0;
            tmo_cnt      <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_error      <= 1'b0;
            if (strobe && (frame_err || (!is_hex && !is_ws))) begin
                shift    <= '0;
                char_cnt <= '0;
                tmo_cnt  <= '0;
                o_error  <= 1'b1;
                state    <= S_IDLE;
            end else if (strobe && is_hex) begin
                shift   <= {shift[DW-5:0], nibble};
                tmo_cnt <= '0;
                if (char_cnt == CNT_LAST) begin
                    o_data       <= {shift[DW-5:0], nibble};
                    o_data_valid <= 1'b1;
                    char_cnt     <= '0;
                    state        <= S_DONE;
                end else begin
                    char_cnt <= char_cnt + 1'b1;
                    state    <= S_COLLECT;
                end
            end else if (state == S_COLLECT) begin
                // Whitespace lands here too, so it never restarts the idle timer.
                if (tmo_cnt == TMO_LAST) begin
                    shift    <= '0;
                    char_cnt <= '0;
                    tmo_cnt  <= '0;
                    o_error  <= 1'b1;
                    state    <= S_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end
        end
    end

    assign o_busy = (state == S_COLLECT);

endmodule
